// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: Philips-format I2S transmitter.
// Holds one stereo pair behind a valid/ready handshake, divides ACLK down to
// BCLK, and shifts each channel MSB-first one BCLK after the LRCLK edge.
// Frames with no pending pair are sent as zeros and flagged by an underrun pulse.
// Optional build macro I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_cnt output. The counter is cleared only by ARESET.
module i2s_tx_serializer #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              frame_start,
  output logic              underrun,
  output logic              busy
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  // The shift register holds frame bits 1..FRAME_W-1.
  // Bit 0 of each frame is produced directly at load time.
  localparam int SH_W    = FRAME_W - 1;

  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              frame_start_q, frame_start_d;
  logic              underrun_q, underrun_d;
  logic              busy_q, busy_d;
  logic              pend_full_q, pend_full_d;
  logic [DATA_W-1:0] pend_left_q, pend_left_d;
  logic [DATA_W-1:0] pend_right_q, pend_right_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic              prev_lsb_q, prev_lsb_d;
  logic [SH_W-1:0]   load_vec;
  logic              fall_evt;
  logic              load_evt;

  // Map the pending pair onto transmit positions 1..FRAME_W-1.
  // The MSB of load_vec is transmitted first.
  for (genvar gi = 1; gi < FRAME_W; gi++) begin : g_frame_map
    localparam int B   = gi % SLOT_W;
    localparam int POS = FRAME_W - 1 - gi;
    if (B >= 1 && B <= DATA_W) begin : g_data
      if (gi < SLOT_W) begin : g_left
        assign load_vec[POS] = pend_left_q[DATA_W-B];
      end else begin : g_right
        assign load_vec[POS] = pend_right_q[DATA_W-B];
      end
    end else if (B == 0 && DATA_W == SLOT_W) begin : g_left_lsb
      // A full-width sample spills its LSB into the first bit of the next slot.
      assign load_vec[POS] = pend_left_q[0];
    end else begin : g_pad
      assign load_vec[POS] = 1'b0;
    end
  end

  // Next-state logic: clock division, bit counting, framing and handshake.
  always_comb begin
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    busy_d        = busy_q;
    pend_full_d   = pend_full_q;
    pend_left_d   = pend_left_q;
    pend_right_d  = pend_right_q;
    shift_d       = shift_q;
    prev_lsb_d    = prev_lsb_q;
    fall_evt      = 1'b0;
    load_evt      = 1'b0;

    if (!enable) begin
      div_cnt_d  = '0;
      bit_cnt_d  = BIT_LAST;
      bclk_d     = 1'b0;
      lrclk_d    = 1'b0;
      sdata_d    = 1'b0;
      busy_d     = 1'b0;
      shift_d    = '0;
      prev_lsb_d = 1'b0;
    end else begin
      busy_d = 1'b1;
      if (div_cnt_q == DIV_TC) begin
        div_cnt_d = '0;
        bclk_d    = ~bclk_q;
        fall_evt  = bclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end

      if (fall_evt) begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          load_evt  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        lrclk_d = (bit_cnt_d >= SLOT_CNT);

        if (load_evt) begin
          // Bit 0 of a frame is the previous right LSB when samples fill the slot.
          sdata_d       = (DATA_W == SLOT_W) ? prev_lsb_q : 1'b0;
          shift_d       = pend_full_q ? load_vec : '0;
          prev_lsb_d    = pend_full_q ? pend_right_q[0] : 1'b0;
          frame_start_d = 1'b1;
          underrun_d    = ~pend_full_q;
        end else begin
          sdata_d = shift_q[SH_W-1];
          shift_d = shift_q << 1;
        end
      end
    end

    // An accept needs pend_full_q low.
    // A load that consumes the pair needs it high, so the two never collide.
    if (s_valid && !pend_full_q) begin
      pend_full_d  = 1'b1;
      pend_left_d  = s_left;
      pend_right_d = s_right;
    end else if (load_evt) begin
      pend_full_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= BIT_LAST;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      busy_q        <= 1'b0;
      pend_full_q   <= 1'b0;
      pend_left_q   <= '0;
      pend_right_q  <= '0;
      shift_q       <= '0;
      prev_lsb_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      busy_q        <= busy_d;
      pend_full_q   <= pend_full_d;
      pend_left_q   <= pend_left_d;
      pend_right_q  <= pend_right_d;
      shift_q       <= shift_d;
      prev_lsb_q    <= prev_lsb_d;
    end
  end

  assign s_ready     = ~pend_full_q;
  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign busy        = busy_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q, urun_cnt_d;

  // Saturating count of underrun frames.
  // The count advances on the same edge as the pulse.
  always_comb begin
    urun_cnt_d = urun_cnt_q;
    if (underrun_d && (urun_cnt_q != 16'hFFFF)) begin
      urun_cnt_d = urun_cnt_q + 16'd1;
    end
  end

  // Underrun counter register.
  // Only ARESET clears it; enable has no effect on it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      urun_cnt_q <= '0;
    end else begin
      urun_cnt_q <= urun_cnt_d;
    end
  end

  assign underrun_cnt = urun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Testbench for i2s_tx_serializer.
// Instance 0 uses DATA_W=24 and instance 1 uses DATA_W=32.
// Both use SLOT_W=32 and BCLK_DIV=2 and share the control inputs.
module tb_i2s_tx_serializer;
  localparam int SW    = 32;
  localparam int DIV   = 2;
  localparam int FRAME = 2 * SW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [23:0] l_a = '0, r_a = '0;
  logic [31:0] l_b = '0, r_b = '0;

  logic [1:0]  o_ready, o_bclk, o_lrclk, o_sdata, o_fs, o_ur, o_busy;
  logic [15:0] o_cnt [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  i2s_tx_serializer #(.DATA_W(24), .SLOT_W(SW), .BCLK_DIV(DIV)) dut_a (
    .ACLK(clk), .ARESET(rst), .enable(enable), .s_valid(s_valid),
    .s_ready(o_ready[0]), .s_left(l_a), .s_right(r_a),
    .i2s_bclk(o_bclk[0]), .i2s_lrclk(o_lrclk[0]), .i2s_sdata(o_sdata[0]),
    .frame_start(o_fs[0]), .underrun(o_ur[0]), .busy(o_busy[0])
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(o_cnt[0])
`endif
  );

  i2s_tx_serializer #(.DATA_W(32), .SLOT_W(SW), .BCLK_DIV(DIV)) dut_b (
    .ACLK(clk), .ARESET(rst), .enable(enable), .s_valid(s_valid),
    .s_ready(o_ready[1]), .s_left(l_b), .s_right(r_b),
    .i2s_bclk(o_bclk[1]), .i2s_lrclk(o_lrclk[1]), .i2s_sdata(o_sdata[1]),
    .frame_start(o_fs[1]), .underrun(o_ur[1]), .busy(o_busy[1])
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(o_cnt[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // j_m counts ACLK edges since enable was first sampled high (-1 = idle).
  // Everything else follows from j_m by arithmetic.
  int          j_m = -1;
  int          cyc = 0;
  bit          pend_m = 0;
  logic [31:0] pl_m [2], pr_m [2], cl_m [2], cr_m [2];
  bit          prev_m [2];
  int          urc_m = 0;
  bit          fs_m = 0, ur_m = 0, acc_flag = 0;

  function automatic logic exp_bit(input int i, input int n);
    int dw, b;
    logic [31:0] s;
    dw = (i == 0) ? 24 : 32;
    b  = n % SW;
    s  = (n >= SW) ? cr_m[i] : cl_m[i];
    if (b >= 1 && b <= dw) return s[dw-b];
    if (b == 0 && dw == SW) return (n >= SW) ? cl_m[i][0] : prev_m[i];
    return 1'b0;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      pl_m[i] = '0; pr_m[i] = '0; cl_m[i] = '0; cr_m[i] = '0; prev_m[i] = 0;
    end
    forever begin
      bit ld, was_pend;
      int f, n;
      logic e_bclk, e_lr, e_sd;
      @(posedge clk);
      cyc++;
      acc_flag = 0; fs_m = 0; ur_m = 0; ld = 0;
      if (rst) begin
        j_m = -1; pend_m = 0; urc_m = 0;
        for (int i = 0; i < 2; i++) begin
          cl_m[i] = '0; cr_m[i] = '0; prev_m[i] = 0;
        end
      end else begin
        was_pend = pend_m;
        if (enable) begin
          j_m++;
          if (((j_m + 1) % (2 * DIV)) == 0 && ((((j_m + 1) / (2 * DIV)) - 1) % FRAME) == 0) ld = 1;
        end else begin
          j_m = -1;
          for (int i = 0; i < 2; i++) begin
            cl_m[i] = '0; cr_m[i] = '0; prev_m[i] = 0;
          end
        end
        if (ld) begin
          fs_m = 1;
          for (int i = 0; i < 2; i++) begin
            prev_m[i] = cr_m[i][0];
            cl_m[i] = was_pend ? pl_m[i] : '0;
            cr_m[i] = was_pend ? pr_m[i] : '0;
          end
          if (!was_pend) begin
            ur_m = 1;
            if (urc_m < 65535) urc_m++;
          end else begin
            pend_m = 0;
          end
        end
        if (s_valid && !was_pend) begin
          pend_m = 1; acc_flag = 1;
          pl_m[0] = {8'h00, l_a}; pr_m[0] = {8'h00, r_a};
          pl_m[1] = l_b;          pr_m[1] = r_b;
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        e_bclk = (j_m >= 0) ? logic'(((j_m + 1) / DIV) % 2) : 1'b0;
        f = (j_m >= 0) ? (j_m + 1) / (2 * DIV) : 0;
        if (f == 0) begin
          e_lr = 1'b0; e_sd = 1'b0;
        end else begin
          n = (f - 1) % FRAME;
          e_lr = (n >= SW);
          e_sd = exp_bit(i, n);
        end
        check($sformatf("s_ready[%0d]", i), {31'd0, o_ready[i]}, {31'd0, ~pend_m});
        check($sformatf("bclk[%0d]", i), {31'd0, o_bclk[i]}, {31'd0, e_bclk});
        check($sformatf("lrclk[%0d]", i), {31'd0, o_lrclk[i]}, {31'd0, e_lr});
        check($sformatf("sdata[%0d]", i), {31'd0, o_sdata[i]}, {31'd0, e_sd});
        check($sformatf("frame_start[%0d]", i), {31'd0, o_fs[i]}, {31'd0, fs_m});
        check($sformatf("underrun[%0d]", i), {31'd0, o_ur[i]}, {31'd0, ur_m});
        check($sformatf("busy[%0d]", i), {31'd0, o_busy[i]}, {31'd0, (j_m >= 0)});
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check($sformatf("underrun_cnt[%0d]", i), {16'd0, o_cnt[i]}, urc_m);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [23:0] la, input logic [23:0] ra,
                      input logic [31:0] lb, input logic [31:0] rb);
    bit ok;
    ok = 0;
    @(negedge clk);
    l_a = la; r_a = ra; l_b = lb; r_b = rb; s_valid = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #2;
      if (acc_flag) begin
        ok = 1;
        break;
      end
    end
    check("push_accepted", {31'd0, ok}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int en_at;
    int ur, ones;
    logic [63:0] bits_a, lr_a;
    logic [23:0] vec;

    bits_a = '0; lr_a = '0; en_at = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_s_ready", {31'd0, o_ready[0]}, 32'd1);
    check("reset_busy", {31'd0, o_busy[0]}, 32'd0);
    check("reset_bclk", {31'd0, o_bclk[1]}, 32'd0);

    // Basic frame with L=A5A5A5 and R=5A5A5A.
    push(24'hA5A5A5, 24'h5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5B);
    @(negedge clk); enable = 1'b1; en_at = cyc + 1;
    wait_cyc(en_at + 2);
    check("t2_no_fs_before_cycle4", {31'd0, o_fs[0]}, 32'd0);
    check("t2_ready_low_before_load", {31'd0, o_ready[0]}, 32'd0);
    wait_cyc(en_at + 3);
    check("t2_fs_at_cycle4", {31'd0, o_fs[0]}, 32'd1);
    check("t2_ready_after_load", {31'd0, o_ready[0]}, 32'd1);
    for (int n = 1; n < FRAME; n++) begin
      wait_cyc(en_at + 3 + 4 * n);
      bits_a[n] = o_sdata[0];
      lr_a[n] = o_lrclk[0];
    end
    vec = '0;
    for (int n = 1; n <= 24; n++) vec = {vec[22:0], bits_a[n]};
    check("t2_left_word", {8'd0, vec}, 32'h00A5A5A5);
    vec = '0;
    for (int n = 33; n <= 56; n++) vec = {vec[22:0], bits_a[n]};
    check("t2_right_word", {8'd0, vec}, 32'h005A5A5A);
    check("t2_left_pad", {25'd0, bits_a[31:25]}, 32'd0);
    check("t2_right_pad", {24'd0, bits_a[63:57], bits_a[32]}, 32'd0);
    check("t2_lrclk_n31", {31'd0, lr_a[31]}, 32'd0);
    check("t2_lrclk_n32", {31'd0, lr_a[32]}, 32'd1);
    @(negedge clk); enable = 1'b0;

    // Three frames with nothing pushed.
    @(negedge clk); enable = 1'b1; en_at = cyc + 1;
    ur = 0; ones = 0;
    for (int c = 0; c < 3 * 256; c++) begin
      wait_cyc(en_at + c);
      ur += int'(o_ur[0]) + int'(o_ur[1]);
      ones += int'(o_sdata[0]) + int'(o_sdata[1]);
    end
    check("t3_underrun_pulses", ur, 32'd6);
    check("t3_sdata_ones", ones, 32'd0);
    @(negedge clk); enable = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    #1;
    check("t3_underrun_cnt", {16'd0, o_cnt[0]}, 32'd3);
`endif

    // Back-to-back pairs; the second one stalls until the first load.
    push(24'h123456, 24'h654321, 32'hCAFEF00D, 32'h00000001);
    fork
      push(24'hFEDCBA, 24'h0F0F0F, 32'h80000000, 32'h7FFFFFFE);
      begin
        @(negedge clk); enable = 1'b1; en_at = cyc + 1;
        wait_cyc(en_at + 2);
        check("t4_second_stalled", {31'd0, o_ready[0]}, 32'd0);
        wait_cyc(en_at + 3);
        check("t4_fs1", {31'd0, o_fs[0]}, 32'd1);
        check("t4_no_underrun1", {31'd0, o_ur[0]}, 32'd0);
      end
    join
    wait_cyc(en_at + 131);
    check("t6_left_lsb_in_right_slot", {31'd0, o_sdata[1]}, 32'd1);
    check("t6_lrclk_n32", {31'd0, o_lrclk[1]}, 32'd1);
    check("t4_a_pad_n32", {31'd0, o_sdata[0]}, 32'd0);
    wait_cyc(en_at + 259);
    check("t6_prev_right_lsb", {31'd0, o_sdata[1]}, 32'd1);
    check("t4_a_bit0_zero", {31'd0, o_sdata[0]}, 32'd0);
    check("t4_fs2", {31'd0, o_fs[0]}, 32'd1);
    check("t4_no_underrun2", {31'd0, o_ur[1]}, 32'd0);
    wait_cyc(en_at + 263);
    check("t4_frame2_msb_a", {31'd0, o_sdata[0]}, 32'd1);
    check("t4_frame2_msb_b", {31'd0, o_sdata[1]}, 32'd1);
    wait_cyc(en_at + 300);
    @(negedge clk); enable = 1'b0;

    // Disable mid-frame with a pending pair, then re-enable.
    @(negedge clk); enable = 1'b1; en_at = cyc + 1;
    wait_cyc(en_at + 10);
    push(24'h800001, 24'h000003, 32'hFFFF0000, 32'h0000FFFF);
    wait_cyc(en_at + 163);
    check("t5_lrclk_n40", {31'd0, o_lrclk[0]}, 32'd1);
    check("t5_pending", {31'd0, o_ready[0]}, 32'd0);
    @(negedge clk); enable = 1'b0;
    wait_cyc(en_at + 164);
    check("t5_off_bclk", {31'd0, o_bclk[0]}, 32'd0);
    check("t5_off_lrclk", {31'd0, o_lrclk[0]}, 32'd0);
    check("t5_off_sdata", {31'd0, o_sdata[1]}, 32'd0);
    check("t5_off_busy", {31'd0, o_busy[0]}, 32'd0);
    check("t5_still_pending", {31'd0, o_ready[0]}, 32'd0);
    wait_cyc(en_at + 170);
    @(negedge clk); enable = 1'b1; en_at = cyc + 1;
    wait_cyc(en_at + 3);
    check("t5_reload_fs", {31'd0, o_fs[0]}, 32'd1);
    check("t5_reload_no_underrun", {31'd0, o_ur[0]}, 32'd0);
    check("t5_reload_ready", {31'd0, o_ready[0]}, 32'd1);
    wait_cyc(en_at + 7);
    check("t5_pending_msb", {31'd0, o_sdata[0]}, 32'd1);
    wait_cyc(en_at + 3 + 4 * 24);
    check("t5_pending_lsb", {31'd0, o_sdata[0]}, 32'd1);
    wait_cyc(en_at + 120);
    @(negedge clk); enable = 1'b0;

    // Asynchronous reset in the middle of a run.
    @(negedge clk); enable = 1'b1; en_at = cyc + 1;
    wait_cyc(en_at + 10);
    push(24'h111111, 24'h222222, 32'h00000003, 32'h00000004);
    wait_cyc(en_at + 50);
    check("t1_bclk_high_before_rst", {31'd0, o_bclk[0]}, 32'd1);
    check("t1_pending_before_rst", {31'd0, o_ready[0]}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t1_async_bclk", {31'd0, o_bclk[0]}, 32'd0);
    check("t1_async_busy", {31'd0, o_busy[1]}, 32'd0);
    check("t1_async_ready", {31'd0, o_ready[0]}, 32'd1);
    @(negedge clk); enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t1_ready_after_release", {31'd0, o_ready[1]}, 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("t1_cnt_cleared", {16'd0, o_cnt[0]}, 32'd0);
`endif
    @(negedge clk); enable = 1'b1; en_at = cyc + 1;
    wait_cyc(en_at + 2);
    check("t1_no_early_fs", {31'd0, o_fs[0]}, 32'd0);
    wait_cyc(en_at + 3);
    check("t1_idle_first_load", {31'd0, o_fs[0]}, 32'd1);
    check("t1_first_load_underrun", {31'd0, o_ur[0]}, 32'd1);
    @(negedge clk); enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
